// File: rtl/ram_tdp_be_param_sc.sv
// True-dual-port single-clock RAM with per-lane byte enables, a read stage,
// an optional gated output stage, collision flagging and a post-reset clear.
//
// state | meaning
// CLEAR | zeroing address clrCnt each cycle, port accesses ignored
// READY | normal dual-port operation
module ram_tdp_be_param_sc #(
  parameter int DATA_WIDTH     = 36,
  parameter int ADDR_WIDTH     = 10,
  parameter int BE_WIDTH       = 4,
  parameter int READ_MODE      = 0,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  weA,
  input  logic                  weB,
  input  logic                  reA,
  input  logic                  reB,
  input  logic [BE_WIDTH-1:0]   beA,
  input  logic [BE_WIDTH-1:0]   beB,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] dinB,
  input  logic                  outA_enable,
  input  logic                  outB_enable,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  doutA_valid,
  output logic                  doutB_valid,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / BE_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   clrCnt, clrCntNext;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    busy;
  logic                    wrA, wrB, rdEnA, rdEnB;
  logic [DATA_WIDTH-1:0]   oldA, oldB, mergeA, mergeB, rdNextA, rdNextB;
  logic [DATA_WIDTH-1:0]   rdA, rdB;
  logic                    rdValA, rdValB;
  logic                    conflict;

  // State register and clear counter; reset restarts the clear from address 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if (CLEAR_ON_RESET != 0) state <= CLEAR;
      else                     state <= READY;
      clrCnt <= '0;
    end else begin
      state  <= stateNext;
      clrCnt <= clrCntNext;
    end
  end

  // Next-state: walk every address once, then hand over to the ports
  always_comb begin
    stateNext  = state;
    clrCntNext = clrCnt;
    case (state)
      CLEAR: begin
        clrCntNext = clrCnt + 1'b1;
        if (&clrCnt) stateNext = READY;
      end
      READY: ;
      default: stateNext = READY;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign init_busy = busy;
  assign wrA       = weA & ~busy;
  assign wrB       = weB & ~busy;
  assign rdEnA     = reA & ~busy;
  assign rdEnB     = reB & ~busy;

  // Old words and same-port merged words for write-first reads
  always_comb begin
    oldA   = mem[addrA];
    oldB   = mem[addrB];
    mergeA = oldA;
    mergeB = oldB;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (beA[i]) mergeA[i*LW +: LW] = dinA[i*LW +: LW];
      if (beB[i]) mergeB[i*LW +: LW] = dinB[i*LW +: LW];
    end
    rdNextA = (READ_MODE == 1 && wrA) ? mergeA : oldA;
    rdNextB = (READ_MODE == 1 && wrB) ? mergeB : oldB;
  end

  // Array write: clear has priority; on overlapping lanes A is applied last so it wins
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clrCnt] <= '0;
    end else begin
      for (int i = 0; i < BE_WIDTH; i++)
        if (wrB && beB[i]) mem[addrB][i*LW +: LW] <= dinB[i*LW +: LW];
      for (int i = 0; i < BE_WIDTH; i++)
        if (wrA && beA[i]) mem[addrA][i*LW +: LW] <= dinA[i*LW +: LW];
    end
  end

  // Read stage: data held when idle, valid tracks accepted reads
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdA    <= '0;
      rdB    <= '0;
      rdValA <= 1'b0;
      rdValB <= 1'b0;
    end else begin
      rdValA <= rdEnA;
      rdValB <= rdEnB;
      if (rdEnA) rdA <= rdNextA;
      if (rdEnB) rdB <= rdNextB;
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      // Output stage loads only when its enable is high
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          doutA       <= '0;
          doutB       <= '0;
          doutA_valid <= 1'b0;
          doutB_valid <= 1'b0;
        end else begin
          if (outA_enable) begin
            doutA       <= rdA;
            doutA_valid <= rdValA;
          end
          if (outB_enable) begin
            doutB       <= rdB;
            doutB_valid <= rdValB;
          end
        end
      end
    end else begin : gOutBypass
      assign doutA       = rdA;
      assign doutB       = rdB;
      assign doutA_valid = rdValA;
      assign doutB_valid = rdValB;
    end
  endgenerate

  // Same-address conflict: overlapping dual writes, or a write against a read
  always_comb begin
    conflict = ~busy && (addrA == addrB) &&
               ((weA && weB && (|(beA & beB))) || (weA && reB) || (weB && reA));
  end

  // Collision is reported one cycle after the conflicting access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) collision <= 1'b0;
    else       collision <= conflict;
  end

endmodule

// File: tb/tb_ram_tdp_be_param_sc.sv
// Bench for ram_tdp_be_param_sc: a default build plus a write-first build share stimulus.
module tb_ram_tdp_be_param_sc;
  localparam int DW = 36;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int LW = DW / BW;

  logic clk, rstn;
  logic weA, weB, reA, reB;
  logic [BW-1:0] beA, beB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, dinB;
  logic outA_enable, outB_enable;
  logic [DW-1:0] doutA, doutB, doutA2, doutB2;
  logic doutA_valid, doutB_valid, vA2, vB2;
  logic init_busy, collision, busy2, coll2;

  ram_tdp_be_param_sc #(.READ_MODE(0)) dut (
    .clk(clk), .rstn(rstn), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .beA(beA), .beB(beB), .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .outA_enable(outA_enable), .outB_enable(outB_enable),
    .doutA(doutA), .doutB(doutB), .doutA_valid(doutA_valid), .doutB_valid(doutB_valid),
    .init_busy(init_busy), .collision(collision));

  ram_tdp_be_param_sc #(.READ_MODE(1)) dut2 (
    .clk(clk), .rstn(rstn), .weA(weA), .weB(weB), .reA(reA), .reB(reB),
    .beA(beA), .beB(beB), .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .outA_enable(outA_enable), .outB_enable(outB_enable),
    .doutA(doutA2), .doutB(doutB2), .doutA_valid(vA2), .doutB_valid(vB2),
    .init_busy(busy2), .collision(coll2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int numChecks = 0;
  int numPass   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got === exp) numPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard queues, one per port per build
  logic [DW-1:0] qA[$], qB[$], q2A[$], q2B[$];
  logic ldA, ldB;

  always @(posedge clk) begin
    ldA <= outA_enable;
    ldB <= outB_enable;
  end

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (doutA_valid && ldA) begin
      if (qA.size() == 0) checkVal("unexp_vA", 1, 0);
      else begin e = qA.pop_front(); checkVal("doutA", doutA, e); end
    end
    if (doutB_valid && ldB) begin
      if (qB.size() == 0) checkVal("unexp_vB", 1, 0);
      else begin e = qB.pop_front(); checkVal("doutB", doutB, e); end
    end
    if (vA2 && ldA) begin
      if (q2A.size() == 0) checkVal("unexp_vA2", 1, 0);
      else begin e = q2A.pop_front(); checkVal("doutA2", doutA2, e); end
    end
    if (vB2 && ldB) begin
      if (q2B.size() == 0) checkVal("unexp_vB2", 1, 0);
      else begin e = q2B.pop_front(); checkVal("doutB2", doutB2, e); end
    end
  end

  task automatic idle();
    weA = 0; weB = 0; reA = 0; reB = 0; beA = '0; beB = '0;
  endtask

  task automatic pushA(input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    qA.push_back(e1); q2A.push_back(e2);
  endtask

  task automatic pushB(input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    qB.push_back(e1); q2B.push_back(e2);
  endtask

  task automatic drain();
    int k = 0;
    while ((qA.size() + qB.size() + q2A.size() + q2B.size()) != 0 && k < 20) begin
      @(negedge clk); k++;
    end
    checkVal("drain", qA.size() + qB.size() + q2A.size() + q2B.size(), 0);
  endtask

  task automatic countClear(input string tag);
    int n = 0;
    logic sawV = 0, sawC = 0;
    while (init_busy && n < 2000) begin
      @(posedge clk); #1; n++;
      sawV |= doutA_valid | doutB_valid;
      sawC |= collision;
    end
    checkVal(tag, n, 1024);
    checkVal({tag, "_vld"}, sawV, 0);
    checkVal({tag, "_coll"}, sawC, 0);
    checkVal({tag, "_busy2"}, busy2, 0);
  endtask

  logic [DW-1:0] mdl [8];
  logic [63:0] r;
  logic [DW-1:0] d, val5, merged;
  logic [BW-1:0] bm;
  int idx;

  initial begin
    rstn = 0; idle(); addrA = '0; addrB = '0; dinA = '0; dinB = '0;
    outA_enable = 1; outB_enable = 1;
    repeat (3) @(negedge clk);
    checkVal("rst_doutA", doutA, 0);
    checkVal("rst_vA", doutA_valid, 0);
    checkVal("rst_doutB", doutB, 0);
    checkVal("rst_coll", collision, 0);
    checkVal("rst_busy", init_busy, 1);

    // Release and hammer both ports during the clear: everything must be ignored
    rstn = 1;
    weA = 1; addrA = 0; dinA = '1; beA = '1; reA = 1;
    weB = 1; addrB = 0; dinB = '1; beB = '1; reB = 1;
    countClear("clr_cycles");
    idle();
    @(negedge clk);

    reA = 1; addrA = 10'h3FF; pushA(0, 0);
    reB = 1; addrB = 10'h000; pushB(0, 0);
    @(negedge clk); idle();
    drain();

    // Byte enables: lanes 0 and 2 cleared, lanes 1 and 3 stay all-ones
    weA = 1; addrA = 5; dinA = 36'hF_FFFF_FFFF; beA = 4'hF;
    @(negedge clk);
    dinA = '0; beA = 4'b0101;
    @(negedge clk); idle();
    val5 = {9'h1FF, 9'h000, 9'h1FF, 9'h000};
    reB = 1; addrB = 5; pushB(val5, val5);
    @(negedge clk); idle();
    drain();

    // Random single-port writes to addresses 16..23 against a lane-merge model
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(7);
      r = {$urandom(), $urandom()};
      d = r[DW-1:0];
      bm = BW'($urandom_range(15));
      for (int l = 0; l < BW; l++) if (bm[l]) mdl[idx][l*LW +: LW] = d[l*LW +: LW];
      if ($urandom_range(1) == 0) begin
        weA = 1; addrA = AW'(16 + idx); dinA = d; beA = bm;
      end else begin
        weB = 1; addrB = AW'(16 + idx); dinB = d; beB = bm;
      end
      @(negedge clk); idle();
    end
    for (int j = 0; j < 8; j++) begin
      reA = 1; addrA = AW'(16 + j); pushA(mdl[j], mdl[j]);
      reB = 1; addrB = AW'(16 + ((j + 3) % 8)); pushB(mdl[(j + 3) % 8], mdl[(j + 3) % 8]);
      @(negedge clk);
    end
    idle();
    drain();

    // Same-port read-during-write: old word in read-first, merged word in write-first
    weA = 1; addrA = 7; dinA = 36'h123; beA = 4'hF;
    @(negedge clk);
    reA = 1; dinA = 36'h456; pushA(36'h123, 36'h456);
    @(negedge clk); idle();
    reB = 1; addrB = 7; pushB(36'h456, 36'h456);
    @(negedge clk); idle();
    drain();

    // Dual write to one address, all lanes: collision for one cycle, A wins
    weA = 1; addrA = 9; dinA = 36'hAAA; beA = 4'hF;
    weB = 1; addrB = 9; dinB = 36'hBBB; beB = 4'hF;
    @(posedge clk); #1;
    checkVal("coll_ww", collision, 1);
    checkVal("coll2_ww", coll2, 1);
    idle();
    @(posedge clk); #1;
    checkVal("coll_ww_end", collision, 0);
    @(negedge clk);
    reA = 1; addrA = 9; pushA(36'hAAA, 36'hAAA);
    @(negedge clk); idle();

    // Write A against read B at one address: collision, B sees old word
    weA = 1; addrA = 12; dinA = 36'h777; beA = 4'hF;
    reB = 1; addrB = 12; pushB(0, 0);
    @(posedge clk); #1;
    checkVal("coll_wr", collision, 1);
    idle();
    @(posedge clk); #1;
    checkVal("coll_wr_end", collision, 0);
    @(negedge clk);

    // Disjoint lanes from both ports: no conflict, both halves land
    weA = 1; addrA = 15; dinA = 36'h1_1111_1111; beA = 4'b0011;
    weB = 1; addrB = 15; dinB = 36'h2_2222_2222; beB = 4'b1100;
    merged = {dinB[DW-1:2*LW], dinA[2*LW-1:0]};
    @(posedge clk); #1;
    checkVal("coll_disj", collision, 0);
    idle();
    @(negedge clk);
    reA = 1; addrA = 15; pushA(merged, merged);
    reB = 1; addrB = 12; pushB(36'h777, 36'h777);
    @(negedge clk); idle();
    drain();

    // Output enable: hold while low, load on the edge after it rises
    reA = 1; addrA = 7; pushA(36'h456, 36'h456);
    @(negedge clk); idle();
    @(negedge clk);
    outA_enable = 0; reA = 1; addrA = 5;
    @(negedge clk);
    @(negedge clk);
    checkVal("oe_hold_d", doutA, 36'h456);
    checkVal("oe_hold_v", doutA_valid, 1);
    outA_enable = 1; reA = 0; pushA(val5, val5);
    @(negedge clk); idle();
    drain();
    repeat (3) @(negedge clk);

    // Async reset, then a reset during the clear that restarts it from zero
    rstn = 0; #1;
    checkVal("arst_doutA", doutA, 0);
    checkVal("arst_vA", doutA_valid, 0);
    checkVal("arst_busy", init_busy, 1);
    @(negedge clk); rstn = 1;
    repeat (300) @(negedge clk);
    checkVal("mid_busy", init_busy, 1);
    rstn = 0; #1;
    checkVal("mid_rst_busy", init_busy, 1);
    @(negedge clk); rstn = 1;
    countClear("reclr_cycles");
    @(negedge clk);
    reA = 1; addrA = 5; pushA(0, 0);
    reB = 1; addrB = 9; pushB(0, 0);
    @(negedge clk); idle();
    drain();

    $display("%0d/%0d checks passed", numPass, numChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
